// File: rtl/sha256_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_pkg : shared FSM states, padding constant and block-count helper. Rev 1.0
// ---------------------------------------------------------------------------
package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  // Message words plus the pad word and the two length words must fit.
  function automatic int unsigned num_blocks(input int unsigned n_words);
    return (n_words + 2) / 16 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_padder : reads a fixed-length message from memory and emits padded
// 512-bit SHA-256 blocks through a valid/ready handshake.          Rev 1.0
// ---------------------------------------------------------------------------
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         mem_clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         done,
  output logic [15:0]  mem_addr,
  output logic         mem_we,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic [7:0]   blk_index
);

  localparam int unsigned NB       = num_blocks(NUM_OF_WORDS);
  localparam logic [7:0]  LAST_B   = 8'(NB - 1);
  localparam logic [15:0] N16      = 16'(NUM_OF_WORDS);
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

  state_t      r_state;
  logic [7:0]  r_b;
  logic [4:0]  r_k;
  logic [31:0] r_words [16];

  logic [15:0] w_g;
  logic [15:0] w_gp;
  logic [3:0]  w_wi;
  logic        w_last_blk;

  assign w_g        = {4'd0, r_b, 4'd0} + {11'd0, r_k};
  assign w_gp       = w_g - 16'd1;
  assign w_wi       = r_k[3:0] - 4'd1;
  assign w_last_blk = (r_b == LAST_B);

  function automatic logic [31:0] word_src(input logic [15:0] gp,
                                           input logic        is_len,
                                           input logic [31:0] rd);
    if (gp < N16)       return rd;
    else if (gp == N16) return PAD_WORD;
    else if (is_len)    return LEN_BITS;
    else                return 32'd0;
  endfunction

  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_b     <= 8'd0;
      r_k     <= 5'd0;
      for (int i = 0; i < 16; i++) r_words[i] <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_b     <= 8'd0;
            r_k     <= 5'd0;
          end
        end
        S_FETCH: begin
          // Read data lags the address by one cycle, so cycle k stores word k-1.
          if (r_k != 5'd0)
            r_words[w_wi] <= word_src(w_gp, (w_wi == 4'd15) && w_last_blk, mem_read_data);
          if (r_k == 5'd16) begin
            r_state <= S_EMIT;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
        S_EMIT: begin
          if (blk_ready) begin
            if (w_last_blk) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
              r_b     <= r_b + 8'd1;
              r_k     <= 5'd0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = 16'd0;
    if (r_state == S_FETCH) begin
      mem_addr = message_addr;
      if ((r_k <= 5'd15) && (w_g < N16)) mem_addr = message_addr + w_g;
    end
  end

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = r_words[i];
  end

  assign done      = (r_state == S_IDLE);
  assign blk_valid = (r_state == S_EMIT);
  assign blk_last  = blk_valid && w_last_blk;
  assign blk_index = r_b;
  assign mem_we    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_padder : three padder instances (20, 13, 14 words) against a
// hand-computed table of expected block words plus handshake sequences. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sha256_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rstn_v, start_v, rdy_v, done_v, we_v, val_v, last_v;
  logic [2:0][15:0]  addr_v, base_v;
  logic [2:0][511:0] data_v;
  logic [2:0][7:0]   idx_v;
  logic [31:0]       mem [0:65535];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NW = (g == 0) ? 20 : ((g == 1) ? 13 : 14);
    logic [31:0] rd;
    always @(posedge clk) rd <= mem[addr_v[g]];
    sha256_padder #(.NUM_OF_WORDS(NW)) u_dut (
      .mem_clk      (clk),
      .reset_n      (rstn_v[g]),
      .start        (start_v[g]),
      .message_addr (base_v[g]),
      .done         (done_v[g]),
      .mem_addr     (addr_v[g]),
      .mem_we       (we_v[g]),
      .mem_read_data(rd),
      .blk_valid    (val_v[g]),
      .blk_ready    (rdy_v[g]),
      .blk_data     (data_v[g]),
      .blk_last     (last_v[g]),
      .blk_index    (idx_v[g])
    );
  end

  typedef struct {
    int          n;
    logic [511:0] d;
    logic        last;
    logic [7:0]  idx;
  } cap_t;

  typedef struct {
    int          n;
    int          blk;
    int          w;
    logic [31:0] exp;
  } vec_t;

  cap_t caps[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (val_v[i] && rdy_v[i]) caps.push_back('{i, data_v[i], last_v[i], idx_v[i]});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input int b, input int w, input logic [31:0] e);
    vecs.push_back('{n, b, w, e});
  endtask

  function automatic int count_inst(input int inst);
    int c = 0;
    foreach (caps[i]) if (caps[i].n == inst) c++;
    return c;
  endfunction

  task automatic clear_inst(input int inst);
    cap_t keep[$];
    foreach (caps[i]) if (caps[i].n != inst) keep.push_back(caps[i]);
    caps = keep;
  endtask

  task automatic check_inst(input int inst, input int nb);
    cap_t         got[$];
    logic [511:0] blk;
    foreach (caps[i]) if (caps[i].n == inst) got.push_back(caps[i]);
    chk($sformatf("blk_count_n%0d", inst), 32'(got.size()), 32'(nb));
    foreach (vecs[v]) begin
      if (vecs[v].n == inst && vecs[v].blk < got.size()) begin
        blk = got[vecs[v].blk].d;
        chk($sformatf("word_n%0d_b%0d_w%0d", inst, vecs[v].blk, vecs[v].w),
            blk[511 - 32*vecs[v].w -: 32], vecs[v].exp);
      end
    end
    foreach (got[j]) begin
      chk($sformatf("blk_index_n%0d_b%0d", inst, j), 32'(got[j].idx), 32'(j));
      chk($sformatf("blk_last_n%0d_b%0d", inst, j), 32'(got[j].last), 32'(j == nb - 1));
    end
    clear_inst(inst);
  endtask

  task automatic pulse_start(input int inst);
    start_v[inst] = 1'b1;
    tick();
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_valid(input int inst, input int maxc);
    int c = 0;
    while (!val_v[inst] && c < maxc) begin
      tick();
      c++;
    end
    chk($sformatf("wait_valid_n%0d", inst), 32'(val_v[inst]), 32'd1);
  endtask

  task automatic wait_done(input int inst, input int maxc);
    int c = 0;
    while (!done_v[inst] && c < maxc) begin
      tick();
      c++;
    end
    chk($sformatf("wait_done_n%0d", inst), 32'(done_v[inst]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] snap;

    rstn_v  = 3'b000;
    start_v = 3'b000;
    rdy_v   = 3'b000;
    base_v[0] = 16'hFFF8;
    base_v[1] = 16'h0100;
    base_v[2] = 16'h0200;
    for (int a = 0; a < 65536; a++) mem[a] = 32'hBAD0_0000 | 32'(a);
    for (int i = 0; i < 20; i++) mem[16'(16'hFFF8 + 16'(i))] = 32'(i + 1);
    for (int i = 0; i < 13; i++) mem[16'h0100 + i] = 32'(i + 1);
    for (int i = 0; i < 14; i++) mem[16'h0200 + i] = 32'(i + 1);

    // Expected block words, derived by hand from the padding rules.
    for (int w = 0; w < 16; w++) add(0, 0, w, 32'(w + 1));
    for (int w = 0; w < 4; w++)  add(0, 1, w, 32'(w + 17));
    add(0, 1, 4, 32'h8000_0000);
    for (int w = 5; w < 15; w++) add(0, 1, w, 32'd0);
    add(0, 1, 15, 32'h0000_0280);
    for (int w = 0; w < 13; w++) add(1, 0, w, 32'(w + 1));
    add(1, 0, 13, 32'h8000_0000);
    add(1, 0, 14, 32'd0);
    add(1, 0, 15, 32'h0000_01A0);
    for (int w = 0; w < 14; w++) add(2, 0, w, 32'(w + 1));
    add(2, 0, 14, 32'h8000_0000);
    add(2, 0, 15, 32'd0);
    for (int w = 0; w < 15; w++) add(2, 1, w, 32'd0);
    add(2, 1, 15, 32'h0000_01C0);

    repeat (3) tick();
    chk("rst_done",  32'(done_v[0]), 32'd1);
    chk("rst_valid", 32'(val_v[0]), 32'd0);
    chk("rst_last",  32'(last_v[0]), 32'd0);
    chk("rst_index", 32'(idx_v[0]), 32'd0);
    chk("rst_data",  32'(data_v[0] == '0), 32'd1);
    chk("rst_addr",  32'(addr_v[0]), 32'd0);
    chk("rst_we",    32'(we_v[0]), 32'd0);
    rstn_v = 3'b111;
    tick();

    // 20-word message, base near the top of memory so addresses wrap.
    rdy_v[0] = 1'b1;
    pulse_start(0);
    chk("fetch_k0_addr", 32'(addr_v[0]), 32'h0000_FFF8);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 8)  chk("fetch_k8_addr_wrap", 32'(addr_v[0]), 32'h0000_0000);
      if (c == 16) chk("valid_low_edge16", 32'(val_v[0]), 32'd0);
      if (c == 17) chk("valid_high_edge17", 32'(val_v[0]), 32'd1);
    end
    wait_done(0, 100);
    check_inst(0, 2);

    // 13- and 14-word messages together.
    rdy_v[1] = 1'b1;
    rdy_v[2] = 1'b1;
    start_v[1] = 1'b1;
    start_v[2] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    start_v[2] = 1'b0;
    wait_done(1, 100);
    wait_done(2, 100);
    check_inst(1, 1);
    check_inst(2, 2);

    // Backpressure: ready low through several EMIT cycles.
    rdy_v[0] = 1'b0;
    pulse_start(0);
    wait_valid(0, 40);
    snap = data_v[0];
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_valid_c%0d", c), 32'(val_v[0]), 32'd1);
      chk($sformatf("bp_data_c%0d", c), 32'(data_v[0] == snap), 32'd1);
    end
    rdy_v[0] = 1'b1;
    wait_done(0, 100);
    check_inst(0, 2);

    // Reset at FETCH k=8 of block 1, then a clean rerun.
    pulse_start(0);
    wait_valid(0, 40);
    tick();
    repeat (8) tick();
    rstn_v[0] = 1'b0;
    #1;
    chk("abort_done",  32'(done_v[0]), 32'd1);
    chk("abort_valid", 32'(val_v[0]), 32'd0);
    clear_inst(0);
    tick();
    rstn_v[0] = 1'b1;
    repeat (20) tick();
    chk("abort_no_block_valid", 32'(val_v[0]), 32'd0);
    chk("abort_no_block_cnt", 32'(count_inst(0)), 32'd0);
    pulse_start(0);
    wait_done(0, 100);
    check_inst(0, 2);

    // Start pulsed during EMIT is ignored.
    rdy_v[0] = 1'b0;
    pulse_start(0);
    wait_valid(0, 40);
    pulse_start(0);
    tick();
    rdy_v[0] = 1'b1;
    wait_done(0, 100);
    check_inst(0, 2);
    repeat (25) tick();
    chk("emit_start_ignored_done",  32'(done_v[0]), 32'd1);
    chk("emit_start_ignored_cnt",   32'(count_inst(0)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, giving the message length in 32-bit words (legal range 1..4000).
REQ-002 SHALL have port mem_clk, input, 1, clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, begins padding of one message when sampled high in IDLE.
REQ-005 SHALL have port message_addr, input, 16, word address of message word 0.
REQ-006 SHALL have port done, output, 1, high while in IDLE.
REQ-007 SHALL have port mem_addr, output, 16, memory read address.
REQ-008 SHALL have port mem_we, output, 1, tied to 0.
REQ-009 SHALL have port mem_read_data, input, 32, read data; valid one cycle after its address is presented.
REQ-010 SHALL have port blk_valid, output, 1, padded 512-bit block available.
REQ-011 SHALL have port blk_ready, input, 1, the downstream hash core accepts a block.
REQ-012 SHALL have port blk_data, output, 512, block; word 0 in [511:480], word 15 in [31:0].
REQ-013 SHALL have port blk_last, output, 1, high with the final block of the message.
REQ-014 SHALL have port blk_index, output, 8, zero-based block number.

Function
REQ-015 SHALL compute the block count NB = floor((NUM_OF_WORDS+2)/16)+1 at elaboration.
REQ-016 SHALL use the states IDLE, FETCH and EMIT.
REQ-017 IDLE: SHALL move to FETCH on start=1, clearing the block counter b and the word counter k; start SHALL be ignored in FETCH and EMIT.
REQ-018 FETCH: k SHALL run 0..16, one value per cycle, exactly 17 cycles per block, regardless of padding.
REQ-019 FETCH, global index g=16*b+k: for k<=15 and g<NUM_OF_WORDS, mem_addr SHALL be message_addr+g; otherwise mem_addr SHALL equal message_addr.
REQ-020 FETCH, cycle k>=1: word k-1 SHALL be stored from the source selected by g'=16*b+k-1:
 - mem_read_data if g'<NUM_OF_WORDS;
 - 32'h80000000 if g'==NUM_OF_WORDS;
 - NUM_OF_WORDS*32 (32-bit) if k-1==15 and b==NB-1;
 - 0 otherwise, including word 14 of the last block (length high word).
REQ-021 FETCH to EMIT SHALL occur on the edge ending k=16; blk_valid SHALL rise 17 edges after the edge that sampled start.
REQ-022 EMIT: blk_valid=1; blk_data, blk_last (b==NB-1) and blk_index (b) SHALL hold stable until blk_valid&&blk_ready.
REQ-023 Handshake in EMIT: if not last, b increments, k clears and the state returns to FETCH; if last, the state returns to IDLE.
REQ-024 blk_ready SHALL be ignored outside EMIT; blk_ready high on the first EMIT cycle completes the transfer in that cycle.
REQ-025 blk_valid SHALL be 0 in IDLE and FETCH; no block SHALL be emitted twice or skipped.
REQ-026 Address arithmetic SHALL be 16-bit modulo, wrapping past 16'hFFFF.

Reset
REQ-027 While reset_n=0, the outputs SHALL be: state IDLE, done=1, blk_valid=0, blk_last=0, blk_index=0, blk_data=0, mem_addr=0, mem_we=0.
REQ-028 Reset asserted mid-FETCH or mid-EMIT SHALL abort the message immediately; no partial block is presented after release.

Structure
REQ-029 Package sha256_pkg SHALL hold the state enum, the padding constant 32'h80000000 and the block-count function; the downstream hash core shares this package.
REQ-030 The block SHALL have no sub-module; the word-source select is a local function.

Verification
REQ-031 NUM_OF_WORDS=20, mem[i]=i+1, blk_ready=1 -> 2 blocks:
 - blk0 = words 1..16, blk_last=0;
 - blk1 w0..3=17..20, w4=0x80000000, w5..14=0, w15=0x280, blk_last=1;
 - then done=1.
REQ-032 NUM_OF_WORDS=13 -> 1 block; w13=0x80000000, w14=0, w15=0x1A0, blk_last=1, blk_index=0.
REQ-033 NUM_OF_WORDS=14 -> 2 blocks:
 - blk0 w14=0x80000000, w15=0;
 - blk1 all zero except w15=0x1C0.
REQ-034 blk_ready held low for 5 EMIT cycles -> blk_valid stays 1 and blk_data is unchanged; a single transfer occurs on the first ready cycle.
REQ-035 reset_n pulsed low at FETCH k=8 of blk1 -> done=1, blk_valid=0; a new start reproduces the REQ-031 output exactly.
REQ-036 start pulsed during EMIT -> ignored; block count and contents are unchanged.
